match_controller: RTL and testbench
===================================

# match_controller

Game-flow sequencer that sits between the frame-timing source and `game_logic`. It gates the per-frame update strobe, issues a serve reset, detects goals from the ball X coordinate, keeps both scores and declares a winner. The display and overlay logic read its state and scores.

## Interface
- `SCORE_W`, 4: score counter width.
- `WIN_SCORE`, 9: points needed to win; must be ≤ 2^SCORE_W − 1.
- `SERVE_FRAMES`, 60: frames spent frozen in SERVE before play.
- `POINT_FRAMES`, 30: frames spent frozen in POINT after a goal.
- `GOAL_L`, 2: ball X at or below this value is a goal on the left (PC) side.
- `GOAL_R`, `SCREEN_H_RES − 2`: ball X at or above this value is a goal on the right (player) side.

- `clk_i`  input  1  system clock.
- `rst_ni`  input  1  asynchronous active-low reset.
- `new_frame_i`  input  1  one-cycle frame tick.
- `keys_i`  input  `KEYS_W`  raw keys, level; bit 2 is start, bit 3 is pause. `KEYS_W` ≥ 4.
- `ball_x_i`  input  `X_POS_W`  current ball X from `game_logic`.
- `frame_en_o`  output  1  gated frame tick to `game_logic`.
- `serve_rst_o`  output  1  one-cycle active-high reset pulse to `game_logic`.
- `state_o`  output  3  encoded state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5.
- `player_score_o`  output  `SCORE_W`  player points.
- `pc_score_o`  output  `SCORE_W`  PC points.
- `winner_o`  output  1  0 = player, 1 = PC; valid in OVER.

## Operation
- Start and pause keys are registered once. A press is the rising edge between the registered value and its previous value.
- IDLE:
  - Scores are held at 0.
  - A start press moves to SERVE, clears both scores and pulses `serve_rst_o`.
- SERVE:
  - The frame counter loads `SERVE_FRAMES − 1` on entry and decrements on each `new_frame_i`.
  - On a tick with counter = 0, go to PLAY.
- PLAY:
  - `frame_en_o` follows `new_frame_i`.
  - On each `new_frame_i`, sample `ball_x_i`.
  - If ≤ `GOAL_L`: increment the player score and go to POINT.
  - Else if ≥ `GOAL_R`: increment the PC score and go to POINT.
  - Goals are checked before the pause press; a goal wins over a simultaneous pause.
- POINT:
  - The counter loads `POINT_FRAMES − 1` on entry and counts down the same way as in SERVE.
  - At expiry, if either score equals `WIN_SCORE`, go to OVER and latch `winner_o`.
  - Otherwise go to SERVE and pulse `serve_rst_o`.
- OVER:
  - Scores and `winner_o` are held.
  - A start press goes to SERVE, clears scores and pulses `serve_rst_o`.
- PAUSE:
  - `frame_en_o` is held at 0 and the counter is frozen.
  - A pause press returns to PLAY.
  - A start press is ignored.
- Score increments saturate at `WIN_SCORE`; no wrap.
- Frame counter is 8 bits and never underflows; all `*_FRAMES` parameters are ≥ 1 and ≤ 256.
- `frame_en_o` is 0 in every state except PLAY.

## Timing
- All outputs are registered.
- `frame_en_o` is asserted the cycle after a `new_frame_i` that arrives while in PLAY, so latency is 1 cycle.
- `serve_rst_o` is high for exactly one cycle, the same cycle `state_o` first shows SERVE.
- A state transition on a tick is visible on `state_o` the cycle after `new_frame_i`.
- A score increment is visible in the same cycle as the state change to POINT.
- Key-triggered transitions are visible 2 cycles after the raw key rises: 1 cycle for the input register, 1 for the state register.
- Reset values:
  - `state_o` = IDLE, scores = 0, `winner_o` = 0.
  - `frame_en_o` = 0, `serve_rst_o` = 0, counter = 0, key registers = 0.
- Reset asserted mid-operation returns to IDLE asynchronously.
  - No `serve_rst_o` pulse is issued on reset release; `game_logic` takes its own reset.
- The frame tick that triggers PLAY→POINT is still forwarded on `frame_en_o`, because gating is decided from the pre-transition state.

## Configuration
- `MATCH_CTRL_PAUSE_EN` defined:
  - PAUSE state is implemented.
  - In PLAY, a pause press with no goal on the same cycle goes to PAUSE.
- `MATCH_CTRL_PAUSE_EN` undefined:
  - `keys_i[3]` is ignored and PAUSE is unreachable.
  - `state_o` never reads 5.

## Test plan
1. Reset, then press start. Required: `state_o` goes 0→1 two cycles after the key rises; `serve_rst_o` pulses once; after 60 ticks `state_o` = 2.
2. In PLAY, hold `ball_x_i` = 1 and give one tick. Required: `player_score_o` = 1, `state_o` = 3; after 30 ticks, SERVE with one `serve_rst_o` pulse.
3. In PLAY, hold `ball_x_i` = `GOAL_R` for 9 point cycles. Required: `pc_score_o` = 9, `state_o` = 4, `winner_o` = 1, `frame_en_o` stays 0 in OVER. A start press then clears the scores and enters SERVE.
4. In PLAY, count forwarded ticks over 10 `new_frame_i` pulses. Required: 10 `frame_en_o` pulses, each 1 cycle after its `new_frame_i`; in SERVE, 0 pulses.
5. With `MATCH_CTRL_PAUSE_EN` defined, press pause in PLAY. Required: `state_o` = 5 and no `frame_en_o` for 5 ticks. Pause again → PLAY. Pause on the same cycle as a goal tick → POINT. Without the macro → stays in PLAY.
6. Deassert `rst_ni` mid-SERVE, off a clock edge. Required: `state_o` = 0 and scores = 0 immediately with no clock edge; no `serve_rst_o` pulse after reset is released.

Source files
------------

// File: rtl/match_controller.sv
// match_controller: game-flow sequencer between frame timing and game_logic.
// Gates the per-frame strobe, issues serve resets, detects goals from the ball
// X position, keeps both scores and latches the winner.
// Optional build macro: MATCH_CTRL_PAUSE_EN adds the PAUSE state (keys_i[3]).
module match_controller #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int KEYS_W       = 4,
    parameter int X_POS_W      = 10,
    parameter int SCREEN_H_RES = 640,
    parameter int GOAL_L       = 2,
    parameter int GOAL_R       = SCREEN_H_RES - 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               new_frame_i,
    input  logic [KEYS_W-1:0]  keys_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    output logic               frame_en_o,
    output logic               serve_rst_o,
    output logic [2:0]         state_o,
    output logic [SCORE_W-1:0] player_score_o,
    output logic [SCORE_W-1:0] pc_score_o,
    output logic               winner_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    localparam logic [7:0]         SERVE_LOAD = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]         POINT_LOAD = 8'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [X_POS_W-1:0] GOAL_L_X   = X_POS_W'(GOAL_L);
    localparam logic [X_POS_W-1:0] GOAL_R_X   = X_POS_W'(GOAL_R);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0] ps_q, ps_d, pc_q, pc_d;
    logic               win_q, win_d;
    logic               fen_q, fen_d;
    logic               srst_q, srst_d;
    logic               start_q, start_prev_q;
    logic               start_press;

    // Only start/pause are consumed; the other key bits are deliberately dropped.
    logic unused_keys;
    assign unused_keys = ^keys_i;

    assign start_press = start_q & ~start_prev_q;

`ifdef MATCH_CTRL_PAUSE_EN
    logic pause_q, pause_prev_q;
    logic pause_press;
    assign pause_press = pause_q & ~pause_prev_q;

    // Pause key register and its delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            pause_q      <= keys_i[3];
            pause_prev_q <= pause_q;
        end
    end
`endif

    // State, counter, scores and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ps_q         <= '0;
            pc_q         <= '0;
            win_q        <= 1'b0;
            fen_q        <= 1'b0;
            srst_q       <= 1'b0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ps_q         <= ps_d;
            pc_q         <= pc_d;
            win_q        <= win_d;
            fen_q        <= fen_d;
            srst_q       <= srst_d;
            start_q      <= keys_i[2];
            start_prev_q <= start_q;
        end
    end

    // Next-state and next-output logic; gating uses the pre-transition state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        pc_d    = pc_q;
        win_d   = win_q;
        fen_d   = 1'b0;
        srst_d  = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_d = S_SERVE;
                    cnt_d   = SERVE_LOAD;
                    srst_d  = 1'b1;
                    ps_d    = '0;
                    pc_d    = '0;
                end
            end
            S_SERVE, S_POINT: begin
                if (new_frame_i) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (state_q == S_SERVE) begin
                        state_d = S_PLAY;
                    end else if (ps_q == WIN_VAL || pc_q == WIN_VAL) begin
                        state_d = S_OVER;
                        win_d   = (pc_q == WIN_VAL);
                    end else begin
                        state_d = S_SERVE;
                        cnt_d   = SERVE_LOAD;
                        srst_d  = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                fen_d = new_frame_i;
                if (new_frame_i && ball_x_i <= GOAL_L_X) begin
                    ps_d    = (ps_q >= WIN_VAL) ? ps_q : ps_q + 1'b1;
                    state_d = S_POINT;
                    cnt_d   = POINT_LOAD;
                end else if (new_frame_i && ball_x_i >= GOAL_R_X) begin
                    pc_d    = (pc_q >= WIN_VAL) ? pc_q : pc_q + 1'b1;
                    state_d = S_POINT;
                    cnt_d   = POINT_LOAD;
                end
`ifdef MATCH_CTRL_PAUSE_EN
                else if (pause_press) begin
                    state_d = S_PAUSE;
                end
`endif
            end
`ifdef MATCH_CTRL_PAUSE_EN
            S_PAUSE: begin
                if (pause_press) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_en_o     = fen_q;
    assign serve_rst_o    = srst_q;
    assign state_o        = state_q;
    assign player_score_o = ps_q;
    assign pc_score_o     = pc_q;
    assign winner_o       = win_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural model of the game flow.
module tb_match_controller;
    localparam int WIN = 9;
    localparam int SF  = 60;
    localparam int PF  = 30;
    localparam int GL  = 2;
    localparam int GR  = 638;
`ifdef MATCH_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       new_frame = 1'b0;
    logic [3:0] keys = 4'd0;
    logic [9:0] ball_x = 10'd320;
    logic       frame_en, serve_rst, winner;
    logic [2:0] state;
    logic [3:0] ps, pc;

    always #5 clk = ~clk;

    match_controller dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .new_frame_i   (new_frame),
        .keys_i        (keys),
        .ball_x_i      (ball_x),
        .frame_en_o    (frame_en),
        .serve_rst_o   (serve_rst),
        .state_o       (state),
        .player_score_o(ps),
        .pc_score_o    (pc),
        .winner_o      (winner)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: states as integers, freezes as "ticks left".
    int m_state, m_left, m_ps, m_pc, m_win, m_fen, m_srst;
    bit ks1, ks2, kp1, kp2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_left = 0; m_ps = 0; m_pc = 0; m_win = 0;
            m_fen = 0; m_srst = 0; ks1 = 0; ks2 = 0; kp1 = 0; kp2 = 0;
        end else begin
            bit sp, pp;
            sp = ks1 && !ks2;
            pp = kp1 && !kp2;
            m_fen = 0;
            m_srst = 0;
            if (m_state == 0 || m_state == 4) begin
                if (sp) begin m_state = 1; m_left = SF; m_srst = 1; m_ps = 0; m_pc = 0; end
            end else if (m_state == 1 || m_state == 3) begin
                if (new_frame) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_state == 1) m_state = 2;
                        else if (m_ps == WIN || m_pc == WIN) begin m_state = 4; m_win = (m_pc == WIN); end
                        else begin m_state = 1; m_left = SF; m_srst = 1; end
                    end
                end
            end else if (m_state == 2) begin
                m_fen = new_frame;
                if (new_frame && ball_x <= GL) begin
                    m_ps = (m_ps < WIN) ? m_ps + 1 : WIN; m_state = 3; m_left = PF;
                end else if (new_frame && ball_x >= GR) begin
                    m_pc = (m_pc < WIN) ? m_pc + 1 : WIN; m_state = 3; m_left = PF;
                end else if (PAUSE_EN && pp) m_state = 5;
            end else if (m_state == 5) begin
                if (pp) m_state = 2;
            end
            ks2 = ks1; ks1 = keys[2];
            kp2 = kp1; kp1 = keys[3];
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("state",     32'(state),     32'(m_state));
        chk("frame_en",  32'(frame_en),  32'(m_fen));
        chk("serve_rst", 32'(serve_rst), 32'(m_srst));
        chk("player",    32'(ps),        32'(m_ps));
        chk("pc",        32'(pc),        32'(m_pc));
        chk("winner",    32'(winner),    32'(m_win));
    end

    // Pulse counters, sampled before the edge updates the outputs.
    int fen_cnt = 0, srst_cnt = 0;
    always @(posedge clk) begin
        if (frame_en === 1'b1) fen_cnt++;
        if (serve_rst === 1'b1) srst_cnt++;
    end

    logic fen_after, srst_after;
    task automatic tick();
        @(negedge clk); new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        fen_after  = frame_en;
        srst_after = serve_rst;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Raise a key and return when the resulting transition is visible.
    task automatic press(input int b);
        @(negedge clk); keys[b] = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, s0;
        // 1: reset and start
        #1 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_scores", 32'({ps, pc}), 0);
        chk("rst_outs", 32'({frame_en, serve_rst, winner}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        press(2);
        chk("start_state", 32'(state), 1);
        chk("start_srst", 32'(serve_rst), 1);
        keys[2] = 1'b0;
        @(negedge clk);
        chk("srst_one_cycle", 32'(serve_rst), 0);
        f0 = fen_cnt;
        ticks(SF - 1);
        chk("serve_hold", 32'(state), 1);
        tick();
        chk("serve_to_play", 32'(state), 2);
        chk("serve_no_fen", 32'(fen_cnt - f0), 0);

        // 4: forwarded ticks in PLAY
        ball_x = 10'd320;
        f0 = fen_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fen_latency", 32'(fen_after), 1);
        end
        chk("fen_count10", 32'(fen_cnt - f0), 10);

        // 2: player goal, then point freeze and re-serve
        ball_x = 10'd1;
        tick();
        chk("goal_fwd", 32'(fen_after), 1);
        chk("goal_player", 32'(ps), 1);
        chk("goal_state", 32'(state), 3);
        ball_x = 10'd320;
        s0 = srst_cnt;
        ticks(PF - 1);
        chk("point_hold", 32'(state), 3);
        tick();
        chk("point_to_serve", 32'(state), 1);
        chk("point_srst", 32'(srst_after), 1);
        ticks(SF);
        chk("reserve_play", 32'(state), 2);
        chk("reserve_pulses", 32'(srst_cnt - s0), 1);

        // 5: pause
        press(3);
        chk("pause_press", 32'(state), PAUSE_EN ? 5 : 2);
        keys[3] = 1'b0;
        if (PAUSE_EN) begin
            f0 = fen_cnt;
            ticks(5);
            chk("pause_hold", 32'(state), 5);
            chk("pause_no_fen", 32'(fen_cnt - f0), 0);
            press(3);
            chk("unpause", 32'(state), 2);
            keys[3] = 1'b0;
        end
        @(negedge clk); keys[3] = 1'b1; ball_x = 10'd1;
        @(negedge clk); new_frame = 1'b1;
        @(negedge clk); new_frame = 1'b0;
        chk("goal_beats_pause", 32'(state), 3);
        chk("goal_beats_pause_ps", 32'(ps), 2);
        keys[3] = 1'b0; ball_x = 10'd320;
        ticks(PF);
        ticks(SF);
        chk("back_to_play", 32'(state), 2);

        // 3: PC wins
        ball_x = 10'(GR);
        for (int i = 0; i < 12 && state != 3'd4; i++) begin
            tick();
            ticks(PF);
            if (state != 3'd4) ticks(SF);
        end
        chk("over_pc", 32'(pc), 9);
        chk("over_ps", 32'(ps), 2);
        chk("over_state", 32'(state), 4);
        chk("over_winner", 32'(winner), 1);
        f0 = fen_cnt;
        ticks(5);
        chk("over_no_fen", 32'(fen_cnt - f0), 0);
        press(2);
        chk("restart_state", 32'(state), 1);
        chk("restart_scores", 32'({ps, pc}), 0);
        chk("restart_srst", 32'(serve_rst), 1);
        keys[2] = 1'b0;
        ball_x = 10'd320;

        // 6: asynchronous reset mid-SERVE with a nonzero score
        ticks(SF);
        ball_x = 10'd1;
        tick();
        ball_x = 10'd320;
        ticks(PF);
        ticks(10);
        chk("pre_rst_state", 32'(state), 1);
        chk("pre_rst_ps", 32'(ps), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_scores", 32'({ps, pc}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = srst_cnt;
        repeat (10) @(negedge clk);
        chk("no_srst_after_rst", 32'(srst_cnt - s0), 0);
        chk("idle_after_rst", 32'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
